stall_fifo: RTL and testbench
=============================

# stall_fifo

Parametrised successor to the fixed 8×32 stall buffer on the global-stall pipeline path. Captures valid stage outputs while `stall` is asserted, then drains them in order, one per cycle, after stall releases. Uses a circular buffer with read/write pointers instead of a shifting register file. Adds configurable width and depth, an almost-full early warning for stall management, an occupancy count, and a sticky overflow flag.

## Interface
- `DATA_W`, 32, payload width in bits
- `DEPTH`, 8, number of storage entries; power of two, ≥ 2
- `AFULL_THRESH`, `DEPTH-1`, occupancy at which `almost_full` asserts; legal range 1..`DEPTH`
- `CNT_W`, `$clog2(DEPTH+1)`, occupancy width (derived, not overridden)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_data`  in  `DATA_W`  payload from upstream stage
- `in_valid`  in  1  `in_data` is valid this cycle
- `stall`  in  1  global stall from stall management
- `flush`  in  1  synchronous discard of all content
- `out_data`  out  `DATA_W`  registered payload to downstream stage
- `out_valid`  out  1  `out_data` valid (registered)
- `full`  out  1  count == `DEPTH`; goes to stall management
- `almost_full`  out  1  count ≥ `AFULL_THRESH`
- `count`  out  `CNT_W`  current occupancy
- `overflow`  out  1  sticky: a valid input was dropped while full

## Operation
- Priority per cycle: reset > flush > stall > drain > bypass.
- Flush:
  - Pointers and count go to 0; `out_valid` ← 0; `overflow` ← 0.
  - `in_data` is ignored that cycle, even if valid.
- Stall:
  - If `in_valid` and not full: write `mem[wr_ptr]`, `wr_ptr` +1, count +1.
  - If `in_valid` and full: drop the input and set `overflow`.
  - `out_valid` ← 0; `out_data` holds.
- Drain (not stall, count > 0):
  - `out_data` ← `mem[rd_ptr]`; `out_valid` ← 1; `rd_ptr` +1.
  - If `in_valid`: also write at `wr_ptr`, so count is unchanged. Otherwise count −1.
  - An input that arrives during drain is always accepted; it is never bypassed ahead of stored entries.
- Bypass (not stall, count == 0): `out_data` ← `in_data`; `out_valid` ← `in_valid`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is the authority for full/empty; there is no pointer-MSB comparison.
- `full`, `almost_full` and `count` are combinational decodes of the count register only. They have no path from the inputs.
- Storage is not reset. `out_data` is only ever loaded from written entries or from `in_data`.

## Timing
- Reset values (asynchronous on `reset_n` low): `out_data`=0, `out_valid`=0, `count`=0, `full`=0, `almost_full`=0, `overflow`=0, pointers=0.
- Bypass latency: 1 cycle, `in_valid` at edge N → `out_valid` after edge N+1.
- Drain: the first stored entry appears after the first non-stall edge. Then one entry per cycle back-to-back, in FIFO order. A stall re-asserted mid-drain freezes the drain on the next edge.
- `full` and `almost_full` reflect a write one edge after it. Stall management sees `full` in the cycle following the `DEPTH`-th write.
- Simultaneous drain and write at count == `DEPTH` is legal. The read frees a slot in the same edge, count stays `DEPTH`, and `overflow` is not set.
- `reset_n` deasserting mid-operation: the block restarts empty. Release is assumed synchronised upstream.

## Structure
- Shared package `stall_fifo_pkg`:
  - default `DATA_W`/`DEPTH` localparams
  - a function returning `CNT_W`
- Sub-module `stall_fifo_mem`: `DEPTH`×`DATA_W` storage with 1 write port and 1 asynchronous read port, no reset.
- Pointer, count, output register and flag logic stay in `stall_fifo`.

## Test plan
- Reset, then 3 valid inputs with no stall (0xA, 0xB, 0xC) → `out_valid`=1 with 0xA, 0xB, 0xC each one cycle later; `count` stays 0.
- Stall for 8 cycles with inputs 1..8 (DEPTH=8) → `count` 1..8, `full`=1 after the 8th edge, `almost_full`=1 after the 7th. Release stall → outputs 1..8 on 8 consecutive cycles; `full` drops after the first drain edge.
- Full and stalled, in_valid with 0x99 → input dropped, `overflow`=1 and stays 1. Subsequent drain yields 1..8 only. `flush` clears `overflow`.
- Stall with 4 stored (1..4), release stall while feeding 5, 6, 7 continuously → output order 1..7; `count` stays 4 during the overlap, then falls to 0.
- Drain of 5 entries interrupted by a 2-cycle stall after the 2nd output → `out_valid`=0 for 2 cycles, then 3, 4, 5 resume in order.
- `flush` asserted together with `stall` and `in_valid` at count 6 → count 0, `out_valid`=0 next cycle, the flushed input is not stored. Asynchronous `reset_n` pulse mid-drain → all outputs are at reset values immediately.

Source files
------------

// File: rtl/stall_fifo_pkg.sv
// Shared defaults and derived-width helper for the stall buffer.
// Parameter values and width helpers used by the stall_fifo block and its storage.
package stall_fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 8;

    // Occupancy must be able to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/stall_fifo_mem.sv
// Storage array for stall_fifo: one synchronous write port, one asynchronous read port, no reset.
module stall_fifo_mem
    import stall_fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int PTR_W  = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read is combinational so a same-edge write at a full buffer still returns the old entry.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stall_fifo.sv
// Circular stall buffer: captures stage outputs while stalled, drains them in order afterwards.
// in_valid qualifies in_data every cycle (no ready); upstream throttles via full/almost_full.
module stall_fifo
    import stall_fifo_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int CNT_W        = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              full,
    output logic              almost_full,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_r;
    logic [DATA_W-1:0] rd_data;
    logic              is_full;
    logic              is_empty;
    logic              do_read;
    logic              do_write;
    logic              drop;

    assign is_full  = (count_r == CNT_W'(DEPTH));
    assign is_empty = (count_r == '0);

    // Flush beats everything; while draining an input is always stored behind older entries.
    assign do_read  = !flush && !stall && !is_empty;
    assign do_write = !flush && in_valid && (stall ? !is_full : !is_empty);
    assign drop     = !flush && stall && in_valid && is_full;

    stall_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_write),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_r  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !do_read) begin
                count_r <= count_r + CNT_W'(1);
            end else if (do_read && !do_write) begin
                count_r <= count_r - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush || stall) begin
            out_valid <= 1'b0;
        end else if (!is_empty) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
        end else begin
            out_data  <= in_data;
            out_valid <= in_valid;
        end
    end

    // Status is decoded from the count register alone, so it never depends on this cycle's inputs.
    assign count       = count_r;
    assign full        = is_full;
    assign almost_full = (count_r >= CNT_W'(AFULL_THRESH));

endmodule

// File: tb/tb_stall_fifo.sv
// Self-checking bench for stall_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_stall_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              full;
    logic              almost_full;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: stored entries in arrival order plus the registered outputs.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_odata;
    logic              m_ovalid;
    logic              m_ov;

    always #5 clk = ~clk;

    stall_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .stall       (stall),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow)
    );

    task automatic model_reset();
        exp_q.delete();
        m_odata  = '0;
        m_ovalid = 1'b0;
        m_ov     = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then settle 1 time unit past the edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic s, input logic f);
        in_valid = v;
        in_data  = d;
        stall    = s;
        flush    = f;
        @(posedge clk);
        if (f) begin
            exp_q.delete();
            m_ov     = 1'b0;
            m_ovalid = 1'b0;
        end else if (s) begin
            if (v) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else m_ov = 1'b1;
            end
            m_ovalid = 1'b0;
        end else if (exp_q.size() > 0) begin
            m_odata  = exp_q.pop_front();
            m_ovalid = 1'b1;
            if (v) exp_q.push_back(d);
        end else begin
            m_odata  = d;
            m_ovalid = v;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, count, full, almost_full, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b d=%0h c=%0d f=%0b af=%0b ov=%0b exp all 0",
                     out_valid, out_data, count, full, almost_full, overflow);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] vals [3];
        vals[0] = 32'hA;
        vals[1] = 32'hB;
        vals[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vals[i], 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || count !== '0) begin
                errors++;
                $display("FAIL bypass_%0d got v=%0b d=%0h c=%0d exp v=1 d=%0h c=0",
                         i, out_valid, out_data, count, vals[i]);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle got v=%0b exp 0", out_valid);
        end
    endtask

    task automatic test_fill_overflow_drain();
        for (int k = 1; k <= DEPTH; k++) begin
            step(1'b1, DATA_W'(k), 1'b1, 1'b0);
            checks++;
            if (count !== CNT_W'(k) || full !== (k == DEPTH) || almost_full !== (k >= DEPTH - 1)
                || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d got c=%0d f=%0b af=%0b v=%0b exp c=%0d f=%0b af=%0b v=0",
                         k, count, full, almost_full, out_valid, k, (k == DEPTH), (k >= DEPTH - 1));
            end
        end
        step(1'b1, 32'h99, 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== CNT_W'(DEPTH)) begin
            errors++;
            $display("FAIL overflow_set got ov=%0b c=%0d exp ov=1 c=%0d", overflow, count, DEPTH);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k) || count !== CNT_W'(DEPTH - k)
                || full !== 1'b0 || overflow !== 1'b1) begin
                errors++;
                $display("FAIL drain_%0d got v=%0b d=%0h c=%0d f=%0b ov=%0b exp v=1 d=%0h c=%0d f=0 ov=1",
                         k, out_valid, out_data, count, full, overflow, k, DEPTH - k);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_end got v=%0b ov=%0b exp v=0 ov=1", out_valid, overflow);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears_overflow got ov=%0b exp 0", overflow);
        end
    endtask

    task automatic test_overlap();
        for (int k = 1; k <= 4; k++) step(1'b1, DATA_W'(k), 1'b1, 1'b0);
        for (int k = 5; k <= 7; k++) begin
            step(1'b1, DATA_W'(k), 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k - 4) || count !== CNT_W'(4)) begin
                errors++;
                $display("FAIL overlap_%0d got v=%0b d=%0h c=%0d exp v=1 d=%0h c=4",
                         k, out_valid, out_data, count, k - 4);
            end
        end
        for (int k = 4; k <= 7; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k) || count !== CNT_W'(7 - k)) begin
                errors++;
                $display("FAIL overlap_tail_%0d got v=%0b d=%0h c=%0d exp v=1 d=%0h c=%0d",
                         k, out_valid, out_data, count, k, 7 - k);
            end
        end
    endtask

    task automatic test_drain_interrupt();
        for (int k = 1; k <= 5; k++) step(1'b1, DATA_W'(k), 1'b1, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k)) begin
                errors++;
                $display("FAIL interrupt_pre_%0d got v=%0b d=%0h exp v=1 d=%0h", k, out_valid, out_data, k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || out_data !== DATA_W'(2) || count !== CNT_W'(3)) begin
                errors++;
                $display("FAIL interrupt_hold_%0d got v=%0b d=%0h c=%0d exp v=0 d=2 c=3",
                         k, out_valid, out_data, count);
            end
        end
        for (int k = 3; k <= 5; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k)) begin
                errors++;
                $display("FAIL interrupt_post_%0d got v=%0b d=%0h exp v=1 d=%0h", k, out_valid, out_data, k);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int k = 1; k <= 6; k++) step(1'b1, DATA_W'(k + 32'h40), 1'b1, 1'b0);
        step(1'b1, 32'h55, 1'b1, 1'b1);
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_state got c=%0d v=%0b f=%0b af=%0b exp c=0 v=0 f=0 af=0",
                     count, out_valid, full, almost_full);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_not_stored got c=%0d v=%0b exp c=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 5; k++) step(1'b1, DATA_W'(k + 32'h70), 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, count, full, almost_full, overflow} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%0b d=%0h c=%0d f=%0b af=%0b ov=%0b exp all 0",
                     out_valid, out_data, count, full, almost_full, overflow);
        end
        model_reset();
        in_valid = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h123, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h123 || count !== '0) begin
            errors++;
            $display("FAIL after_reset_bypass got v=%0b d=%0h c=%0d exp v=1 d=123 c=0",
                     out_valid, out_data, count);
        end
    endtask

    task automatic test_random();
        logic              v;
        logic              s;
        logic              f;
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  exp_cnt;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 6 : 3));
            f = ($urandom_range(0, 39) == 0);
            d = $urandom;
            step(v, d, s, f);
            exp_cnt = CNT_W'(exp_q.size());
            checks++;
            if (out_valid !== m_ovalid || out_data !== m_odata || count !== exp_cnt
                || full !== (exp_q.size() == DEPTH) || almost_full !== (exp_q.size() >= DEPTH - 1)
                || overflow !== m_ov) begin
                errors++;
                $display("FAIL random_%0d got v=%0b d=%0h c=%0d f=%0b af=%0b ov=%0b exp v=%0b d=%0h c=%0d ov=%0b",
                         i, out_valid, out_data, count, full, almost_full, overflow,
                         m_ovalid, m_odata, exp_cnt, m_ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_fill_overflow_drain();
        test_overlap();
        test_drain_interrupt();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
